// File: rtl/ex_pkg.sv
// Shared types and constants for the execute stage and its divider.
package ex_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = $clog2(DATA_W);

  // Result class selected by the decoder
  typedef enum logic [2:0] {
    EXE_RES_NOP   = 3'd0,
    EXE_RES_LOGIC = 3'd1,
    EXE_RES_SHIFT = 3'd2,
    EXE_RES_MOVE  = 3'd3,
    EXE_RES_DIV   = 3'd4
  } alusel_t;

  // Sub-operation within a result class
  typedef enum logic [7:0] {
    EXE_OP_NOP        = 8'h00,
    EXE_OP_SHIFT_SRL  = 8'h02,
    EXE_OP_SHIFT_SRA  = 8'h03,
    EXE_OP_MOVE_MFHI  = 8'h10,
    EXE_OP_MOVE_MTHI  = 8'h11,
    EXE_OP_MOVE_MFLO  = 8'h12,
    EXE_OP_MOVE_MTLO  = 8'h13,
    EXE_OP_DIV_DIV    = 8'h1A,
    EXE_OP_DIV_DIVU   = 8'h1B,
    EXE_OP_LOGIC_AND  = 8'h24,
    EXE_OP_LOGIC_OR   = 8'h25,
    EXE_OP_LOGIC_XOR  = 8'h26,
    EXE_OP_LOGIC_NOR  = 8'h27,
    EXE_OP_SHIFT_SLL  = 8'h7C
  } aluop_t;

  // Divider sequencing states
  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_t;

  // MTHI/MTLO write HI/LO and never write a GPR
  function automatic logic is_mt_op(input aluop_t op);
    return (op == EXE_OP_MOVE_MTHI) || (op == EXE_OP_MOVE_MTLO);
  endfunction

endpackage

// File: rtl/ex_if.sv
// ID/EX bundle into the execute stage plus the results it returns.
interface ex_if;
  import ex_pkg::*;

  alusel_t             alusel_i;
  aluop_t              aluop_i;
  logic [DATA_W-1:0]   reg1_i;
  logic [DATA_W-1:0]   reg2_i;
  logic [ADDR_W-1:0]   waddr_i;
  logic                we_i;
  logic [DATA_W-1:0]   wdata_o;
  logic [ADDR_W-1:0]   waddr_o;
  logic                we_o;
  logic                stallreq_o;
  logic [DATA_W-1:0]   hi_o;
  logic [DATA_W-1:0]   lo_o;

  // Upstream pipeline side
  modport master (
    output alusel_i, aluop_i, reg1_i, reg2_i, waddr_i, we_i,
    input  wdata_o, waddr_o, we_o, stallreq_o, hi_o, lo_o
  );

  // Execute stage side
  modport slave (
    input  alusel_i, aluop_i, reg1_i, reg2_i, waddr_i, we_i,
    output wdata_o, waddr_o, we_o, stallreq_o, hi_o, lo_o
  );

endinterface

// File: rtl/ex_div_unit.sv
// Iterative restoring divider, one quotient bit per cycle.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// DIV_IDLE | waiting for start_i; latches magnitudes and sign flags
// DIV_BUSY | one shift/trial-subtract step per cycle, cnt 0..DATA_W-1
// DIV_DONE | quot_o/rem_o valid for one cycle, then back to idle
module ex_div_unit
  import ex_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              signed_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] quot_o,
  output logic [DATA_W-1:0] rem_o
);

  div_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] quot_q, rem_q, dvs_q;
  logic              sign_a_q, neg_quot_q, div0_q;

  logic              a_neg, b_neg, div_zero, last_step, borrow;
  logic [DATA_W-1:0] a_abs, b_abs;
  logic [DATA_W+1:0] diff;

  assign a_neg     = signed_i & a_i[DATA_W-1];
  assign b_neg     = signed_i & b_i[DATA_W-1];
  assign a_abs     = a_neg ? -a_i : a_i;
  assign b_abs     = b_neg ? -b_i : b_i;
  assign div_zero  = (b_i == '0);
  assign last_step = (cnt_q == CNT_W'(DATA_W - 1));

  // Partial remainder gets the next dividend bit; a borrow means the divisor did not fit
  assign diff   = {1'b0, rem_q, quot_q[DATA_W-1]} - {2'b00, dvs_q};
  assign borrow = diff[DATA_W+1];

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= DIV_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DIV_IDLE: if (start_i) state_d = div_zero ? DIV_DONE : DIV_BUSY;
      DIV_BUSY: if (last_step) state_d = DIV_DONE;
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  // Operand capture and shift/subtract datapath; quot_q starts as |dividend| and fills with quotient bits
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q      <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      sign_a_q   <= 1'b0;
      neg_quot_q <= 1'b0;
      div0_q     <= 1'b0;
    end else begin
      unique case (state_q)
        DIV_IDLE: begin
          if (start_i) begin
            cnt_q      <= '0;
            quot_q     <= a_abs;
            rem_q      <= '0;
            dvs_q      <= b_abs;
            sign_a_q   <= a_neg;
            neg_quot_q <= a_neg ^ b_neg;
            div0_q     <= div_zero;
          end
        end
        DIV_BUSY: begin
          quot_q <= {quot_q[DATA_W-2:0], ~borrow};
          rem_q  <= borrow ? {rem_q[DATA_W-2:0], quot_q[DATA_W-1]} : diff[DATA_W-1:0];
          cnt_q  <= cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Outputs with sign correction; divide-by-zero returns the raw dividend as remainder
  always_comb begin
    busy_o = (state_q == DIV_BUSY);
    done_o = (state_q == DIV_DONE);
    if (div0_q) begin
      quot_o = '1;
      rem_o  = sign_a_q ? -quot_q : quot_q;
    end else begin
      quot_o = neg_quot_q ? -quot_q : quot_q;
      rem_o  = sign_a_q ? -rem_q : rem_q;
    end
  end

endmodule

// File: rtl/ex.sv
// Execute stage: combinational logic/shift/move results, HI/LO registers, divider stall.
module ex
  import ex_pkg::*;
(
  input  logic clk,
  input  logic rst,
  ex_if.slave  bus
);

  logic              is_div, is_mt, div_signed, div_start, div_busy, div_done, stall;
  logic [DATA_W-1:0] quot, rem, result;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;

  assign is_div     = (bus.alusel_i == EXE_RES_DIV);
  assign is_mt      = (bus.alusel_i == EXE_RES_MOVE) && is_mt_op(bus.aluop_i);
  assign div_signed = (bus.aluop_i == EXE_OP_DIV_DIV);
  assign div_start  = is_div && !div_busy && !div_done;
  assign stall      = is_div && !div_done;

  ex_div_unit u_div (
    .clk      (clk),
    .rst      (rst),
    .start_i  (div_start),
    .signed_i (div_signed),
    .a_i      (bus.reg1_i),
    .b_i      (bus.reg2_i),
    .busy_o   (div_busy),
    .done_o   (div_done),
    .quot_o   (quot),
    .rem_o    (rem)
  );

  // Zero-latency result mux so decode can forward from wdata_o
  always_comb begin
    result = '0;
    unique case (bus.alusel_i)
      EXE_RES_LOGIC: begin
        case (bus.aluop_i)
          EXE_OP_LOGIC_AND: result = bus.reg1_i & bus.reg2_i;
          EXE_OP_LOGIC_OR:  result = bus.reg1_i | bus.reg2_i;
          EXE_OP_LOGIC_XOR: result = bus.reg1_i ^ bus.reg2_i;
          EXE_OP_LOGIC_NOR: result = ~(bus.reg1_i | bus.reg2_i);
          default:          result = '0;
        endcase
      end
      EXE_RES_SHIFT: begin
        case (bus.aluop_i)
          EXE_OP_SHIFT_SLL: result = bus.reg2_i << bus.reg1_i[4:0];
          EXE_OP_SHIFT_SRL: result = bus.reg2_i >> bus.reg1_i[4:0];
          EXE_OP_SHIFT_SRA: result = $unsigned($signed(bus.reg2_i) >>> bus.reg1_i[4:0]);
          default:          result = '0;
        endcase
      end
      EXE_RES_MOVE: begin
        case (bus.aluop_i)
          EXE_OP_MOVE_MFHI: result = hi_q;
          EXE_OP_MOVE_MFLO: result = lo_q;
          default:          result = '0;
        endcase
      end
      default: result = '0;
    endcase
  end

  // GPR write-back and stall outputs, held at zero while reset is asserted
  always_comb begin
    bus.wdata_o    = '0;
    bus.waddr_o    = '0;
    bus.we_o       = 1'b0;
    bus.stallreq_o = 1'b0;
    if (rst) begin
      bus.wdata_o    = result;
      bus.waddr_o    = bus.waddr_i;
      bus.we_o       = bus.we_i && !is_div && !is_mt;
      bus.stallreq_o = stall;
    end
  end

  // HI/LO next value: divider result on completion, otherwise MTHI/MTLO
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (div_done) begin
      hi_d = rem;
      lo_d = quot;
    end else if (!stall && bus.alusel_i == EXE_RES_MOVE) begin
      if (bus.aluop_i == EXE_OP_MOVE_MTHI) hi_d = bus.reg1_i;
      if (bus.aluop_i == EXE_OP_MOVE_MTLO) lo_d = bus.reg1_i;
    end
  end

  // HI/LO registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign bus.hi_o = hi_q;
  assign bus.lo_o = lo_q;

endmodule

// File: tb/tb_ex.sv
// Directed plus randomized bench for the execute stage against a behavioural model.
module tb_ex;
  import ex_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  ex_if bus ();

  ex dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input alusel_t s, input aluop_t o, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [4:0] wa, input logic w);
    bus.alusel_i = s;
    bus.aluop_i  = o;
    bus.reg1_i   = r1;
    bus.reg2_i   = r2;
    bus.waddr_i  = wa;
    bus.we_i     = w;
  endtask

  function automatic logic [31:0] ref_result(input alusel_t s, input aluop_t o,
                                             input logic [31:0] r1, input logic [31:0] r2);
    int unsigned sh;
    sh = int'(r1 % 32);
    case (s)
      EXE_RES_LOGIC:
        case (o)
          EXE_OP_LOGIC_AND: return r1 & r2;
          EXE_OP_LOGIC_OR:  return r1 | r2;
          EXE_OP_LOGIC_XOR: return r1 ^ r2;
          EXE_OP_LOGIC_NOR: return ~(r1 | r2);
          default:          return 32'h0;
        endcase
      EXE_RES_SHIFT:
        case (o)
          EXE_OP_SHIFT_SLL: return r2 << sh;
          EXE_OP_SHIFT_SRL: return r2 >> sh;
          EXE_OP_SHIFT_SRA: return (r2 >> sh) | (r2[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
          default:          return 32'h0;
        endcase
      EXE_RES_MOVE:
        case (o)
          EXE_OP_MOVE_MFHI: return m_hi;
          EXE_OP_MOVE_MFLO: return m_lo;
          default:          return 32'h0;
        endcase
      default: return 32'h0;
    endcase
  endfunction

  task automatic ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    if (b == 32'h0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'h0;
    end else begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
  endtask

  // One single-cycle operation: check combinational outputs, clock it, check HI/LO
  task automatic do_op(input string tag, input alusel_t s, input aluop_t o,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic [4:0] wa, input logic w);
    logic exp_we;
    drive(s, o, r1, r2, wa, w);
    #1;
    exp_we = w && !(s == EXE_RES_MOVE && (o == EXE_OP_MOVE_MTHI || o == EXE_OP_MOVE_MTLO));
    chk({tag, "_wdata"}, bus.wdata_o, ref_result(s, o, r1, r2));
    chk({tag, "_waddr"}, {27'h0, bus.waddr_o}, {27'h0, wa});
    chk({tag, "_we"},    {31'h0, bus.we_o}, {31'h0, exp_we});
    chk({tag, "_stall"}, {31'h0, bus.stallreq_o}, 32'h0);
    tick;
    if (s == EXE_RES_MOVE && o == EXE_OP_MOVE_MTHI) m_hi = r1;
    if (s == EXE_RES_MOVE && o == EXE_OP_MOVE_MTLO) m_lo = r1;
    chk({tag, "_hi"}, bus.hi_o, m_hi);
    chk({tag, "_lo"}, bus.lo_o, m_lo);
  endtask

  // A divide: count stall cycles, watch we_o, then check HI/LO after completion
  task automatic do_div(input string tag, input bit sgn, input logic [31:0] a, input logic [31:0] b);
    int   cycles;
    logic we_seen;
    drive(EXE_RES_DIV, sgn ? EXE_OP_DIV_DIV : EXE_OP_DIV_DIVU, a, b, 5'($urandom), 1'b1);
    #1;
    cycles  = 0;
    we_seen = 1'b0;
    while (bus.stallreq_o === 1'b1 && cycles < 40) begin
      we_seen = we_seen | bus.we_o;
      cycles++;
      tick;
    end
    we_seen = we_seen | bus.we_o;
    chk({tag, "_stall_cycles"}, 32'(cycles), (b == 32'h0) ? 32'd1 : 32'd33);
    chk({tag, "_we"}, {31'h0, we_seen}, 32'h0);
    tick;
    drive(EXE_RES_NOP, EXE_OP_NOP, 32'h0, 32'h0, 5'h0, 1'b0);
    ref_div(sgn, a, b, m_lo, m_hi);
    #1;
    chk({tag, "_lo"}, bus.lo_o, m_lo);
    chk({tag, "_hi"}, bus.hi_o, m_hi);
  endtask

  initial begin
    aluop_t logic_ops [4];
    aluop_t shift_ops [3];
    logic [31:0] a, b;
    logic_ops = '{EXE_OP_LOGIC_AND, EXE_OP_LOGIC_OR, EXE_OP_LOGIC_XOR, EXE_OP_LOGIC_NOR};
    shift_ops = '{EXE_OP_SHIFT_SLL, EXE_OP_SHIFT_SRL, EXE_OP_SHIFT_SRA};

    // Reset state, with a live operation presented to show outputs are held at zero
    rst = 1'b0;
    drive(EXE_RES_LOGIC, EXE_OP_LOGIC_OR, 32'h1234, 32'h5678, 5'd7, 1'b1);
    tick;
    tick;
    chk("rst_wdata", bus.wdata_o, 32'h0);
    chk("rst_waddr", {27'h0, bus.waddr_o}, 32'h0);
    chk("rst_we",    {31'h0, bus.we_o}, 32'h0);
    chk("rst_stall", {31'h0, bus.stallreq_o}, 32'h0);
    chk("rst_hi",    bus.hi_o, 32'h0);
    chk("rst_lo",    bus.lo_o, 32'h0);
    rst = 1'b1;
    drive(EXE_RES_NOP, EXE_OP_NOP, 32'h0, 32'h0, 5'h0, 1'b0);
    tick;

    // Directed cases
    do_op("or",  EXE_RES_LOGIC, EXE_OP_LOGIC_OR, 32'h1100, 32'h0011, 5'd3, 1'b1);
    do_op("sra", EXE_RES_SHIFT, EXE_OP_SHIFT_SRA, 32'd4, 32'h8000_0010, 5'd4, 1'b1);
    do_op("srl", EXE_RES_SHIFT, EXE_OP_SHIFT_SRL, 32'd4, 32'h8000_0010, 5'd4, 1'b1);
    do_op("unk_sel", alusel_t'(3'd7), EXE_OP_LOGIC_OR, 32'hFFFF, 32'hF0F0, 5'd9, 1'b1);
    do_div("divu_100_7", 1'b0, 32'd100, 32'd7);
    do_op("mflo", EXE_RES_MOVE, EXE_OP_MOVE_MFLO, 32'h0, 32'h0, 5'd8, 1'b1);
    chk("mflo_const", m_lo, 32'd14);
    do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    do_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    do_div("divu_5_0", 1'b0, 32'd5, 32'd0);
    do_op("mthi", EXE_RES_MOVE, EXE_OP_MOVE_MTHI, 32'hABCD, 32'h0, 5'd2, 1'b1);
    do_op("mfhi", EXE_RES_MOVE, EXE_OP_MOVE_MFHI, 32'h0, 32'h0, 5'd5, 1'b1);
    do_div("div_m9_0", 1'b1, 32'hFFFF_FFF7, 32'd0);
    do_op("mthi2", EXE_RES_MOVE, EXE_OP_MOVE_MTHI, 32'hABCD, 32'h0, 5'd2, 1'b1);

    // Reset during BUSY cycle 10 aborts the divide and clears HI/LO
    drive(EXE_RES_DIV, EXE_OP_DIV_DIVU, 32'd200, 32'd3, 5'd1, 1'b1);
    repeat (10) tick;
    rst = 1'b0;
    tick;
    drive(EXE_RES_NOP, EXE_OP_NOP, 32'h0, 32'h0, 5'h0, 1'b0);
    m_hi = '0;
    m_lo = '0;
    #1;
    chk("abort_stall", {31'h0, bus.stallreq_o}, 32'h0);
    chk("abort_hi", bus.hi_o, 32'h0);
    chk("abort_lo", bus.lo_o, 32'h0);
    rst = 1'b1;
    tick;
    do_div("divu_9_3", 1'b0, 32'd9, 32'd3);

    // Randomized mix against the model
    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: do_op("r_logic", EXE_RES_LOGIC, logic_ops[$urandom_range(0, 3)], a, b, 5'($urandom), 1'($urandom));
        4, 5:       do_op("r_shift", EXE_RES_SHIFT, shift_ops[$urandom_range(0, 2)], a, b, 5'($urandom), 1'($urandom));
        6: begin
          do_op("r_mthi", EXE_RES_MOVE, EXE_OP_MOVE_MTHI, a, b, 5'($urandom), 1'b1);
          do_op("r_mtlo", EXE_RES_MOVE, EXE_OP_MOVE_MTLO, b, a, 5'($urandom), 1'b1);
        end
        7: begin
          do_op("r_mfhi", EXE_RES_MOVE, EXE_OP_MOVE_MFHI, a, b, 5'($urandom), 1'b1);
          do_op("r_mflo", EXE_RES_MOVE, EXE_OP_MOVE_MFLO, a, b, 5'($urandom), 1'b1);
        end
        8: begin
          if ($urandom_range(0, 3) == 0) b = 32'h0;
          else if ($urandom_range(0, 1) == 0) b = b >> $urandom_range(0, 28);
          do_div("r_div", 1'($urandom), a, b);
        end
        default: do_op("r_unk", alusel_t'(3'($urandom_range(5, 7))), logic_ops[$urandom_range(0, 3)], a, b, 5'($urandom), 1'b1);
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
